// File: rtl/pix_lane_pkg.sv
// Shared definitions for the pixel lane packer.
// Holds the lane/width constants, the packer FSM state type, the lane-word type
// and a helper that turns the requested line length into the effective one.
package pix_lane_pkg;

  localparam int unsigned L        = 4;     // lanes per output word (ports fixed at 4)
  localparam int unsigned DW       = 14;    // pixel width
  localparam int unsigned LINE_MAX = 1024;  // longest line; also used when line_len is 0
  localparam int unsigned CNT_W    = 10;    // clk_cnt width
  localparam int unsigned LEN_W    = 11;    // line_len width

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StPad
  } pack_state_t;

  // Index 0 is the earliest pixel of the word.
  typedef logic [L-1:0][DW-1:0] lane_word_t;

  // Zero means "full line"; anything longer than LINE_MAX is clamped.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > LEN_W'(LINE_MAX)) begin
      return LEN_W'(LINE_MAX);
    end
    return len;
  endfunction

endpackage

// File: rtl/pix_lane_packer.sv
// Serial-to-parallel pixel packer feeding the 4-lane interpolator bus.
// A line starts with a pixel flagged by pix_in_sol_i; pixels are packed four at a
// time into a lane word, and a short final word is padded with the last pixel.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   line_len_i          pixels per line, sampled with the start-of-line pixel
//   pix_in_i/_v_i/_sol_i  serial pixel, valid, start of line
//   pix_in_rdy_o        packer accepts a pixel this cycle (low during padding)
//   sample_out0..3_o    packed lanes, lane 0 earliest; held between pulses
//   sample_out_v_o      one-cycle pulse per packed word
//   clk_cnt_o           1-based word index in the line, 0 after the line ends
//   line_done_o         pulses with the last word of a line
//   err_flags_o         sticky {clamped, sol mid-line, stray pixel}; only with
//                       PIX_PACK_ERR_EN defined
module pix_lane_packer
  import pix_lane_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [LEN_W-1:0] line_len_i,
  input  logic [DW-1:0]    pix_in_i,
  input  logic             pix_in_v_i,
  input  logic             pix_in_sol_i,
  output logic             pix_in_rdy_o,
  output logic [DW-1:0]    sample_out0_o,
  output logic [DW-1:0]    sample_out1_o,
  output logic [DW-1:0]    sample_out2_o,
  output logic [DW-1:0]    sample_out3_o,
  output logic             sample_out_v_o,
  output logic [CNT_W-1:0] clk_cnt_o,
`ifdef PIX_PACK_ERR_EN
  output logic [2:0]       err_flags_o,
`endif
  output logic             line_done_o
);

  pack_state_t      state_q, state_d;
  lane_word_t       lanes_q, lanes_d;
  logic [1:0]       lane_idx_q, lane_idx_d;
  logic [LEN_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [DW-1:0]    last_q, last_d;
  logic             rdy_q;
  lane_word_t       out_word_q, out_word_d;
  logic             out_v_q, out_v_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic             done_q, done_d;
  logic             acc;
  logic             start;

  assign acc = pix_in_v_i & rdy_q;

  always_comb begin
    state_d    = state_q;
    lanes_d    = lanes_q;
    lane_idx_d = lane_idx_q;
    pix_cnt_d  = pix_cnt_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    last_d     = last_q;
    out_word_d = out_word_q;
    out_v_d    = 1'b0;
    done_d     = 1'b0;
    // Index holds between words, drops to zero once the line-done pulse has gone.
    clk_cnt_d  = done_q ? '0 : clk_cnt_q;
    start      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Pixels without sol are dropped here.
        if (acc && pix_in_sol_i) begin
          start = 1'b1;
        end
      end
      StFill: begin
        if (acc && pix_in_sol_i) begin
          // Restart: the partial word is abandoned without output.
          start = 1'b1;
        end else if (acc) begin
          lanes_d[lane_idx_q] = pix_in_i;
          last_d              = pix_in_i;
          lane_idx_d          = lane_idx_q + 2'd1;
          pix_cnt_d           = pix_cnt_q + LEN_W'(1);
          if (lane_idx_q == 2'd3) begin
            out_word_d = lanes_d;
            out_v_d    = 1'b1;
            clk_cnt_d  = word_idx_q + CNT_W'(1);
            word_idx_d = word_idx_q + CNT_W'(1);
          end
          if (pix_cnt_d == len_q) begin
            if (lane_idx_q == 2'd3) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StPad;
            end
          end
        end
      end
      StPad: begin
        // Replicate the last pixel into the unfilled lanes and emit the final word.
        for (int i = 0; i < int'(L); i++) begin
          out_word_d[i] = (i >= int'(lane_idx_q)) ? last_q : lanes_q[i];
        end
        out_v_d    = 1'b1;
        done_d     = 1'b1;
        clk_cnt_d  = word_idx_q + CNT_W'(1);
        word_idx_d = word_idx_q + CNT_W'(1);
        lane_idx_d = 2'd0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      len_d      = clamp_len(line_len_i);
      lanes_d[0] = pix_in_i;
      last_d     = pix_in_i;
      lane_idx_d = 2'd1;
      pix_cnt_d  = LEN_W'(1);
      word_idx_d = '0;
      state_d    = (len_d == LEN_W'(1)) ? StPad : StFill;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      lanes_q    <= '0;
      lane_idx_q <= '0;
      pix_cnt_q  <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      last_q     <= '0;
      rdy_q      <= 1'b0;
      out_word_q <= '0;
      out_v_q    <= 1'b0;
      clk_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lanes_q    <= lanes_d;
      lane_idx_q <= lane_idx_d;
      pix_cnt_q  <= pix_cnt_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      last_q     <= last_d;
      // Registered so it stays low while in reset and during the padding cycle.
      rdy_q      <= (state_d != StPad);
      out_word_q <= out_word_d;
      out_v_q    <= out_v_d;
      clk_cnt_q  <= clk_cnt_d;
      done_q     <= done_d;
    end
  end

`ifdef PIX_PACK_ERR_EN
  logic [2:0] err_q, err_set;

  always_comb begin
    err_set    = '0;
    err_set[0] = (state_q == StIdle) & acc & ~pix_in_sol_i;
    err_set[1] = (state_q == StFill) & acc & pix_in_sol_i;
    err_set[2] = start & (line_len_i > LEN_W'(LINE_MAX));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | err_set;
    end
  end

  assign err_flags_o = err_q;
`endif

  assign pix_in_rdy_o   = rdy_q;
  assign sample_out0_o  = out_word_q[0];
  assign sample_out1_o  = out_word_q[1];
  assign sample_out2_o  = out_word_q[2];
  assign sample_out3_o  = out_word_q[3];
  assign sample_out_v_o = out_v_q;
  assign clk_cnt_o      = clk_cnt_q;
  assign line_done_o    = done_q;

endmodule

// File: tb/tb_pix_lane_packer.sv
// Scoreboard bench for pix_lane_packer: the driver feeds pixels, a line-level
// reference model turns accepted pixels into expected words, and a monitor
// compares every output pulse and the held values in between.
module tb_pix_lane_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] line_len;
  logic [13:0] pix_in;
  logic        pix_in_v;
  logic        pix_in_sol;
  logic        pix_in_rdy;
  logic [13:0] so0, so1, so2, so3;
  logic        sample_out_v;
  logic [9:0]  clk_cnt;
  logic        line_done;
`ifdef PIX_PACK_ERR_EN
  logic [2:0]  err_flags;
`endif

  always #5 clk = ~clk;

  pix_lane_packer dut (
    .clk            (clk),
    .reset          (reset),
    .line_len_i     (line_len),
    .pix_in_i       (pix_in),
    .pix_in_v_i     (pix_in_v),
    .pix_in_sol_i   (pix_in_sol),
    .pix_in_rdy_o   (pix_in_rdy),
    .sample_out0_o  (so0),
    .sample_out1_o  (so1),
    .sample_out2_o  (so2),
    .sample_out3_o  (so3),
    .sample_out_v_o (sample_out_v),
    .clk_cnt_o      (clk_cnt),
`ifdef PIX_PACK_ERR_EN
    .err_flags_o    (err_flags),
`endif
    .line_done_o    (line_done)
  );

  typedef struct {
    logic [55:0] lanes;  // {lane3, lane2, lane1, lane0}
    int          cnt;
    bit          done;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_pulse = 0;
  bit   mon_en = 1'b0;

  // Reference model state: one line in progress at most.
  bit          m_active = 1'b0;
  int          m_len = 0;
  int          m_got = 0;
  int          m_widx = 0;
  logic [13:0] m_buf[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Turn an accepted pixel into zero or one expected word, following the line rules.
  task automatic model_accept(input logic [13:0] p, input bit s, input int len_in, input int at);
    exp_t e;
    if (s) begin
      m_active = 1'b1;
      m_len    = (len_in == 0 || len_in > 1024) ? 1024 : len_in;
      m_got    = 0;
      m_widx   = 0;
      m_buf.delete();
    end
    if (!m_active) return;
    m_buf.push_back(p);
    m_got++;
    if (m_buf.size() == 4 || m_got == m_len) begin
      e.cyc  = (m_buf.size() == 4) ? at : at + 1;
      while (m_buf.size() < 4) m_buf.push_back(p);
      e.lanes = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
      m_widx++;
      e.cnt  = m_widx;
      e.done = (m_got == m_len);
      q.push_back(e);
      m_buf.delete();
      if (e.done) m_active = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_buf.delete();
  endtask

  // Present one pixel and hold it until accepted; returns #1 after the accepting edge.
  task automatic send_pix(input logic [13:0] p, input bit s);
    int guard = 0;
    pix_in     = p;
    pix_in_sol = s;
    pix_in_v   = 1'b1;
    @(negedge clk);
    while (!pix_in_rdy && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rdy_timeout: pix_in_rdy stayed 0, expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    model_accept(p, s, int'(line_len), cyc);
    pix_in_v   = 1'b0;
    pix_in_sol = 1'b0;
  endtask

  task automatic idle_cycle();
    pix_in_v = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 50) begin
      guard++;
      @(posedge clk);
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words pending, expected 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compares pulses against the scoreboard and checks holding between them.
  logic [55:0] hold_lanes = '0;
  int          hold_cnt = 0;
  bit          prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!reset) begin
        hold_lanes = '0;
        hold_cnt   = 0;
        prev_done  = 1'b0;
      end else if (sample_out_v) begin
        n_pulse++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got lanes %h cnt %0d, expected no word",
                   {so3, so2, so1, so0}, clk_cnt);
        end else begin
          e = q.pop_front();
          check("word_lanes", {8'h0, so3, so2, so1, so0}, {8'h0, e.lanes});
          check("word_clk_cnt", 64'(clk_cnt), 64'(e.cnt));
          check("word_line_done", 64'(line_done), 64'(e.done));
          check("word_latency_cycle", 64'(cyc), 64'(e.cyc));
          hold_lanes = e.lanes;
          hold_cnt   = e.cnt;
          prev_done  = e.done;
        end
      end else begin
        if (prev_done) hold_cnt = 0;
        check("hold_state", {7'h0, line_done, so3, so2, so1, so0},
              {8'h0, hold_lanes});
        check("hold_clk_cnt", 64'(clk_cnt), 64'(hold_cnt));
        prev_done = 1'b0;
      end
    end
  end

  initial begin
    int p0;
    reset      = 1'b0;
    pix_in_v   = 1'b0;
    pix_in_sol = 1'b0;
    pix_in     = '0;
    line_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {so3, so2, so1, so0, sample_out_v, clk_cnt, line_done}, '0);
    check("reset_rdy", 64'(pix_in_rdy), 64'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_reset", 64'(pix_in_rdy), 64'd1);

    // 8-pixel line, continuous valid.
    line_len = 11'd8;
    for (int i = 1; i <= 8; i++) send_pix(14'(i), i == 1);
    drain();

    // 6-pixel line: second word padded, pad cycle not ready.
    line_len = 11'd6;
    for (int i = 10; i <= 15; i++) send_pix(14'(i), i == 10);
    check("pad_rdy_low", 64'(pix_in_rdy), 64'd0);
    drain();

    // line_len=0 means a full 1024-pixel line.
    p0 = n_pulse;
    line_len = 11'd0;
    for (int i = 0; i < 1024; i++) send_pix(14'($urandom), i == 0);
    drain();
    check("full_line_pulses", 64'(n_pulse - p0), 64'd256);

    // sol re-asserted at pixel 3 restarts the line.
    line_len = 11'd8;
    send_pix(14'd20, 1'b1);
    send_pix(14'd21, 1'b0);
    line_len = 11'd4;
    for (int i = 22; i <= 25; i++) send_pix(14'(i), i == 22);
    drain();
`ifdef PIX_PACK_ERR_EN
    check("err_mid_sol", 64'(err_flags), 64'b010);
`endif

    // Gapped valid.
    line_len = 11'd4;
    for (int i = 7; i <= 10; i++) begin
      send_pix(14'(i), i == 7);
      idle_cycle();
    end
    drain();

    // Reset after two accepted pixels discards the partial word.
    line_len = 11'd8;
    send_pix(14'd40, 1'b1);
    send_pix(14'd41, 1'b0);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("midreset_outputs", {so3, so2, so1, so0, sample_out_v, clk_cnt, line_done}, '0);
    check("midreset_rdy", 64'(pix_in_rdy), 64'd0);
`ifdef PIX_PACK_ERR_EN
    check("midreset_err", 64'(err_flags), 64'd0);
`endif
    reset = 1'b1;
    line_len = 11'd4;
    for (int i = 30; i <= 33; i++) send_pix(14'(i), i == 30);
    drain();

    // Over-long line_len is clamped to 1024.
    p0 = n_pulse;
    line_len = 11'd2000;
    for (int i = 0; i < 1024; i++) send_pix(14'($urandom), i == 0);
    drain();
    check("clamped_line_pulses", 64'(n_pulse - p0), 64'd256);
`ifdef PIX_PACK_ERR_EN
    check("err_clamp", 64'(err_flags[2]), 64'd1);
`endif

    // Random stream: short lines, gaps, stray pixels, mid-line restarts, and
    // line_len changing on non-sol pixels.
    for (int n = 0; n < 400; n++) begin
      if (!m_active && $urandom_range(0, 9) == 0) begin
        line_len = 11'($urandom);
        send_pix(14'($urandom), 1'b0);
      end else if (!m_active || $urandom_range(0, 19) == 0) begin
        line_len = 11'($urandom_range(1, 24));
        send_pix(14'($urandom), 1'b1);
      end else begin
        line_len = 11'($urandom);
        send_pix(14'($urandom), 1'b0);
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    drain();
    check("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
